// File: rtl/timer_reload_sequencer.sv
// Feeds a down-counting timer from a small interval FIFO: one load pulse per
// interval, advancing on each terminal count until the FIFO runs dry or stop.
module timer_reload_sequencer #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         tc,
  output logic                         load,
  output logic [WIDTH-1:0]             data,
  output logic                         busy,
  output logic                         underrun,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             push;
  logic             pop;
  logic             urun_nxt;

  assign in_ready = (level != FULL);
  assign push     = in_valid & in_ready;
  assign busy     = (state == RUN);

  // Pop decisions look only at the registered level, so a same-cycle push
  // can never be consumed before it lands in the FIFO.
  always_comb begin
    pop       = 1'b0;
    urun_nxt  = 1'b0;
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (level != '0) begin
              pop       = 1'b1;
              state_nxt = RUN;
            end else begin
              urun_nxt  = 1'b1;
            end
          end
        end
        RUN: begin
          // tc during a load cycle reflects the old count and is ignored
          if (tc && !load) begin
            if (level != '0) begin
              pop       = 1'b1;
            end else begin
              urun_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered outputs and FIFO control
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      load     <= 1'b0;
      data     <= '0;
      underrun <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else begin
      state    <= state_nxt;
      load     <= pop;
      underrun <= urun_nxt;
      if (pop) begin
        data   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_timer_reload_sequencer.sv
// Bench for timer_reload_sequencer: a behavioural timer closes the tc loop and
// a scoreboard matches every load/underrun pulse against queued expectations.
module tb_timer_reload_sequencer;

  localparam int WIDTH = 10;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             areset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             tc;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             underrun;
  logic [LW-1:0]    level;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    bit is_load;
    int val;
    int at;
  } ev_t;
  ev_t exp_q[$];

  timer_reload_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .start(start), .stop(stop), .tc(tc), .load(load),
    .data(data), .busy(busy), .underrun(underrun), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Down-counting timer: reload on load, count to zero and hold
  logic [WIDTH-1:0] tcnt = '0;
  always @(posedge clk) begin
    if (load) tcnt <= data;
    else if (tcnt != 0) tcnt <= tcnt - 1'b1;
  end
  assign tc = (tcnt == 0);

  // Monitor: every pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (!areset && (load || underrun)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: load=%0b underrun=%0b data=%0d cycle=%0d, required no pulse",
                 load, underrun, data, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (load !== e.is_load || underrun !== !e.is_load ||
            (e.is_load && data !== WIDTH'(e.val)) || cyc != e.at) begin
          n_fail++;
          $display("FAIL pulse_match: got load=%0b underrun=%0b data=%0d cycle=%0d, required load=%0b underrun=%0b data=%0d cycle=%0d",
                   load, underrun, data, cyc, e.is_load, !e.is_load, e.val, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input bit is_load, input int val, input int at);
    ev_t e;
    e.is_load = is_load;
    e.val     = val;
    e.at      = at;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int v);
    in_valid = 1'b1;
    in_data  = WIDTH'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    areset   = 1'b1;
    tick();
    areset   = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;

    // Reset state
    do_reset();
    check("rst_load", load, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);

    // Intervals 3,10; second push lands in the start cycle (pop+push together)
    push(3);
    start = 1'b1; in_valid = 1'b1; in_data = 10;
    s = cyc;
    expect_ev(1, 3, s + 1);
    expect_ev(1, 10, s + 6);
    expect_ev(0, 0, s + 18);
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("seq1_level_pushpop", level, 1);
    check("seq1_busy", busy, 1);
    tick();
    check("seq1_data_hold", data, 3);
    run_to(s + 18);
    check("seq1_busy_end", busy, 0);
    check("seq1_level_end", level, 0);
    run_to(s + 35);
    drained("seq1_drained");

    // Zero intervals: loads two cycles apart
    do_reset();
    push(0);
    push(0);
    start = 1'b1;
    s = cyc;
    expect_ev(1, 0, s + 1);
    expect_ev(1, 0, s + 3);
    expect_ev(0, 0, s + 5);
    tick();
    start = 1'b0;
    run_to(s + 5);
    check("zero_busy_end", busy, 0);
    run_to(s + 15);
    drained("zero_drained");

    // Start on empty FIFO while pushing: no bypass, underrun only
    do_reset();
    start = 1'b1; in_valid = 1'b1; in_data = 7;
    s = cyc;
    expect_ev(0, 0, s + 1);
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("empty_busy", busy, 0);
    check("empty_level", level, 1);
    run_to(s + 6);
    check("empty_busy_later", busy, 0);
    drained("empty_drained");

    // Full FIFO
    do_reset();
    push(5);
    push(6);
    push(7);
    check("full_ready_at3", in_ready, 1);
    push(8);
    check("full_ready_at4", in_ready, 0);
    check("full_level_at4", level, 4);
    push(9);
    check("full_level_reject", level, 4);
    start = 1'b1; in_valid = 1'b1; in_data = 9;
    s = cyc;
    expect_ev(1, 5, s + 1);
    tick();
    start = 1'b0;
    check("full_level_popped", level, 3);
    check("full_ready_popped", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("full_level_refill", level, 4);
    check("full_ready_refill", in_ready, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("full_busy_stopped", busy, 0);
    check("full_level_stopped", level, 4);
    run_to(s + 20);
    drained("full_drained");

    // Stop mid-interval
    do_reset();
    push(8);
    push(8);
    start = 1'b1;
    s = cyc;
    expect_ev(1, 8, s + 1);
    tick();
    start = 1'b0;
    run_to(s + 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_level", level, 1);
    run_to(s + 30);
    check("stop_busy_later", busy, 0);
    drained("stop_drained");

    // Async reset during a load cycle
    do_reset();
    push(4);
    start = 1'b1;
    s = cyc;
    expect_ev(1, 4, s + 1);
    tick();
    start = 1'b0;
    @(negedge clk);
    #1;
    areset = 1'b1;
    #1;
    check("arst_load", load, 0);
    check("arst_busy", busy, 0);
    check("arst_level", level, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_data", data, 0);
    tick();
    areset = 1'b0;
    tick();
    start = 1'b1;
    s = cyc;
    expect_ev(0, 0, s + 1);
    tick();
    start = 1'b0;
    check("arst_busy_after", busy, 0);
    run_to(s + 6);
    drained("arst_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
